// File: rtl/rr_dec_arbiter.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter
//
// Round-robin arbiter sharing one 3-to-8 decoded select among 8 requesters.
// One requester owns the resource at a time; its index and the decoded
// active-low one-hot select are driven from registers. The owner keeps the
// grant while its request stays high. Every release is followed by one idle
// cycle before the next grant, and the search pointer moves to owner+1.
//
// Optional feature macro: RR_TIMEOUT_EN
//   defined   : hold counter forces a release after HOLD_MAX grant cycles,
//               pulses timeout for one cycle and masks the released owner
//               until it drops its request.
//   undefined : no counter/mask; grant held indefinitely; timeout tied 0.
//
// Parameters
//   HOLD_MAX  grant cycles before forced release (1 .. 2**CNT_W-1)
//   CNT_W     hold counter width
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   req      in   8  level requests, bit i = requester i
//   gnt_vld  out  1  grant active
//   gnt_idx  out  3  owner index (0 when no grant)
//   gnt_n    out  8  active-low one-hot select, 8'hFF when no grant
//   timeout  out  1  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_dec_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       gnt_vld,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_n,
    output logic       timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("rr_dec_arbiter: HOLD_MAX out of range for CNT_W");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nx;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nx;
    logic       r_vld;
    logic       w_vld_nx;
    logic [7:0] r_gnt_n;
    logic [7:0] w_gnt_n_nx;

    logic [7:0] w_elig;      // requests allowed to compete this cycle
    logic [7:0] w_rot;       // w_elig rotated so bit 0 is the ptr position
    logic       w_found;
    logic [2:0] w_off;
    logic [2:0] w_winner;
    logic       w_owner_req;
    logic       w_force;     // forced release this cycle (timeout build only)

    assign w_owner_req = req[r_idx];

`ifdef RR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_hold;
    logic [7:0]       r_mask;
    logic             r_timeout;

    assign w_elig  = req & ~r_mask;
    // r_hold counts completed grant cycles, so the current one is r_hold+1.
    assign w_force = (r_state == S_BUSY) && w_owner_req && (r_hold >= LP_LAST);

    // Held at zero while idle, which gives the clear-on-entry behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == S_IDLE) begin
            r_hold <= '0;
        end else if (r_hold != '1) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // A mask bit survives only while its request stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_mask    <= (r_mask & req) | (w_force ? (8'b1 << r_idx) : 8'b0);
            r_timeout <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_elig  = req;
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    // Rotate eligibility so the search always starts at bit 0, then take
    // the lowest set bit and rotate the offset back.
    always_comb begin
        w_rot = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_rot[k] = w_elig[r_ptr + 3'(k)];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 3'(k);
            end
        end
    end

    assign w_winner = r_ptr + w_off;

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_idx_nx   = r_idx;
        w_vld_nx   = r_vld;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_BUSY;
                    w_vld_nx   = 1'b1;
                    w_idx_nx   = w_winner;
                end
            end
            S_BUSY: begin
                if (!w_owner_req || w_force) begin
                    w_state_nx = S_IDLE;
                    w_vld_nx   = 1'b0;
                    w_idx_nx   = '0;
                    w_ptr_nx   = r_idx + 3'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_vld_nx   = 1'b0;
                w_idx_nx   = '0;
            end
        endcase
        w_gnt_n_nx = ~(8'(w_vld_nx) << w_idx_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_gnt_n <= '1;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_idx   <= w_idx_nx;
            r_vld   <= w_vld_nx;
            r_gnt_n <= w_gnt_n_nx;
        end
    end

    assign gnt_vld = r_vld;
    assign gnt_idx = r_idx;
    assign gnt_n   = r_gnt_n;

endmodule
